// File: rtl/iob_axistream_in_pkg.sv
// Shared constants for the AXI4-Stream byte receiver: register word
// indices, FIFO entry layout and head-prefetch FSM encoding.
package iob_axistream_in_pkg;

   // One FIFO entry holds {tdata, tlast}, with tlast in the LSB
   localparam int ENTRY_W = 9;

   // Register word indices, taken from address[3:2]
   localparam logic [1:0] REG_OUT   = 2'd0;
   localparam logic [1:0] REG_EMPTY = 2'd1;
   localparam logic [1:0] REG_TLAST = 2'd2;
   localparam logic [1:0] REG_NEXT  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   function automatic logic [ENTRY_W-1:0] pack_entry(input logic [7:0] data,
                                                     input logic       last);
      return {data, last};
   endfunction

endpackage

// File: rtl/iob_axistream_in_if.sv
// CPU register bus plus AXI4-Stream receive signals of the stream receiver.
interface iob_axistream_in_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
);
   logic                  valid;
   logic [ADDR_W-1:0]     address;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic [DATA_W-1:0]     rdata;
   logic                  ready;
   logic [7:0]            tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;

   modport master (
      output valid, address, wdata, wstrb, tdata, tvalid, tlast,
      input  rdata, ready, tready
   );

   modport slave (
      input  valid, address, wdata, wstrb, tdata, tvalid, tlast,
      output rdata, ready, tready
   );
endinterface

// File: rtl/iob_fifo_sync.sv
// Synchronous FIFO with registered read data (valid the cycle after r_en).
// Writes when full and reads when empty are dropped internally.
module iob_fifo_sync #(
   parameter int W_DATA_W = 9,
   parameter int R_DATA_W = 9,
   parameter int ADDR_W   = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                w_en_i,
   input  logic [W_DATA_W-1:0] w_data_i,
   output logic                w_full_o,
   input  logic                r_en_i,
   output logic [R_DATA_W-1:0] r_data_o,
   output logic                r_empty_o,
   output logic [ADDR_W:0]     level_o
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [W_DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0]   wptr_q, rptr_q;
   logic [ADDR_W:0]     level_q;
   logic [R_DATA_W-1:0] r_data_q;
   logic                wr, rd;

   assign w_full_o  = (level_q == (ADDR_W+1)'(DEPTH));
   assign r_empty_o = (level_q == '0);
   assign wr        = w_en_i & ~w_full_o;
   assign rd        = r_en_i & ~r_empty_o;
   assign r_data_o  = r_data_q;
   assign level_o   = level_q;

   // Storage array, no reset needed
   always_ff @(posedge clk_i) begin
      if (wr) mem_q[wptr_q] <= w_data_i;
   end

   // Pointers, occupancy and registered read port
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         level_q  <= '0;
         r_data_q <= '0;
      end else begin
         if (wr) wptr_q <= wptr_q + 1'b1;
         if (rd) begin
            rptr_q   <= rptr_q + 1'b1;
            r_data_q <= R_DATA_W'(mem_q[rptr_q]);
         end
         level_q <= level_q + (ADDR_W+1)'(wr) - (ADDR_W+1)'(rd);
      end
   end
endmodule

// File: rtl/iob_axistream_in.sv
// AXI4-Stream byte receiver: beats land in a FIFO, the oldest byte is
// prefetched into a head register that software reads and pops.
module iob_axistream_in
   import iob_axistream_in_pkg::*;
#(
   parameter int DATA_W          = 32,
   parameter int ADDR_W          = 4,
   parameter int FIFO_DEPTH_LOG2 = 4
) (
   input  logic               clk,
   input  logic               rst,
   iob_axistream_in_if.slave  bus_io
);
   logic                       fifo_full, fifo_empty, fifo_r_en, stream_we;
   logic [ENTRY_W-1:0]         fifo_r_data;
   logic [FIFO_DEPTH_LOG2:0]   unused_level;

   state_t                     state_q;
   logic [7:0]                 head_data_q;
   logic                       head_last_q, head_valid_q;
   logic [15:0]                frame_cnt_q;

   logic                       ready_q, ready_d;
   logic [DATA_W-1:0]          rdata_q, rdata_d;
   logic                       req, wr, pop;
   logic [ADDR_W-1:0]          word;
   logic                       unused_bits;

   // tready follows pre-read FIFO status, so a pop in the same cycle
   // cannot make room for a write into a full FIFO
   assign bus_io.tready = ~rst & ~fifo_full;
   assign stream_we     = bus_io.tvalid & bus_io.tready;

   // Prefetch read is issued combinationally from IDLE so a beat shows up
   // in the head register three cycles after it was accepted
   assign fifo_r_en = (state_q == IDLE) & ~fifo_empty & ~head_valid_q;

   // A new request is one not already being acknowledged
   assign req  = bus_io.valid & ~ready_q;
   assign wr   = |bus_io.wstrb;
   assign word = bus_io.address >> 2;
   assign pop  = req & wr & (word == ADDR_W'(REG_NEXT)) & bus_io.wdata[0] & head_valid_q;

   assign bus_io.ready = ready_q;
   assign bus_io.rdata = rdata_q;

   assign unused_bits = ^{bus_io.wdata[DATA_W-1:1], unused_level, frame_cnt_q};

   iob_fifo_sync #(
      .W_DATA_W (ENTRY_W),
      .R_DATA_W (ENTRY_W),
      .ADDR_W   (FIFO_DEPTH_LOG2)
   ) fifo_u (
      .clk_i     (clk),
      .rst_i     (rst),
      .w_en_i    (stream_we),
      .w_data_i  (pack_entry(bus_io.tdata, bus_io.tlast)),
      .w_full_o  (fifo_full),
      .r_en_i    (fifo_r_en),
      .r_data_o  (fifo_r_data),
      .r_empty_o (fifo_empty),
      .level_o   (unused_level)
   );

   // Head prefetch FSM plus frame byte counter updated on each pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         head_data_q  <= '0;
         head_last_q  <= 1'b0;
         head_valid_q <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         unique case (state_q)
            IDLE: if (fifo_r_en) state_q <= FETCH;
            FETCH: begin
               head_data_q  <= fifo_r_data[ENTRY_W-1:1];
               head_last_q  <= fifo_r_data[0];
               head_valid_q <= 1'b1;
               state_q      <= HOLD;
            end
            HOLD: if (pop) begin
               head_valid_q <= 1'b0;
               state_q      <= IDLE;
               if (head_last_q)                frame_cnt_q <= '0;
               else if (frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Register read mux, captured on the request cycle
   always_comb begin
      rdata_d = '0;
      ready_d = req;
      if (req && !wr) begin
         if (word == ADDR_W'(REG_OUT)) begin
            if (head_valid_q) begin
               rdata_d[7:0] = head_data_q;
               if (ADDR_W > 4) rdata_d[23:8] = frame_cnt_q;
            end
         end else if (word == ADDR_W'(REG_EMPTY)) begin
            rdata_d[0] = ~head_valid_q;
         end else if (word == ADDR_W'(REG_TLAST)) begin
            rdata_d[0] = head_last_q & head_valid_q;
         end
      end
   end

   // CPU acknowledge and read data registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         ready_q <= ready_d;
         rdata_q <= rdata_d;
      end
   end
endmodule

// File: tb/tb_iob_axistream_in.sv
// Directed bench for iob_axistream_in with a byte-queue reference model.
module tb_iob_axistream_in;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: bytes accepted by the block and not yet popped, oldest first
   logic [8:0]  mq [$];

   logic        exp_vld = 1'b0;
   logic [31:0] exp_rdata = '0;
   string       exp_name = "";
   logic        prev_req = 1'b0;

   iob_axistream_in_if #(.DATA_W(32), .ADDR_W(4)) bus ();

   iob_axistream_in #(.DATA_W(32), .ADDR_W(4), .FIFO_DEPTH_LOG2(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s: bound expired", nm);
   endtask

   // Compare process: CPU handshake, read data and stream flow control
   always @(negedge clk) begin
      if (rst) begin
         check("rst_tready", {31'd0, bus.tready}, 32'd0);
         check("rst_ready", {31'd0, bus.ready}, 32'd0);
      end else begin
         if (prev_req) begin
            check("ready_pulse", {31'd0, bus.ready}, 32'd1);
            if (exp_vld) check(exp_name, bus.rdata, exp_rdata);
         end else begin
            check("ready_idle", {31'd0, bus.ready}, 32'd0);
         end
         if (bus.tvalid && bus.tready)
            check("no_overflow", {31'd0, mq.size() < 17}, 32'd1);
      end
      prev_req <= bus.valid & ~rst;
   end

   // Starts at #1 after a posedge; two cycles: request then acknowledge
   task automatic cpu_req(input logic [3:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                          input logic chk, input logic [31:0] exp, input string nm,
                          output logic [31:0] rd);
      exp_vld     = chk;
      exp_rdata   = exp;
      exp_name    = nm;
      bus.valid   = 1'b1;
      bus.address = addr;
      bus.wdata   = wd;
      bus.wstrb   = ws;
      @(posedge clk); #1;
      bus.valid   = 1'b0;
      bus.wstrb   = '0;
      rd          = bus.rdata;
      @(posedge clk); #1;
      exp_vld     = 1'b0;
   endtask

   task automatic rd_chk(input logic [3:0] addr, input logic [31:0] exp, input string nm);
      logic [31:0] rd;
      cpu_req(addr, 32'd0, 4'h0, 1'b1, exp, nm, rd);
   endtask

   task automatic wr_next(input logic [31:0] wd);
      logic [31:0] rd;
      cpu_req(4'hC, wd, 4'hF, 1'b0, 32'd0, "", rd);
   endtask

   task automatic poll_head(input string nm);
      logic [31:0] rd;
      logic        ok;
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         cpu_req(4'h4, 32'd0, 4'h0, 1'b0, 32'd0, "", rd);
         if (rd[0] == 1'b0) ok = 1'b1;
      end
      if (!ok) fail_now({nm, "_poll"});
   endtask

   // Wait for the head, compare it with the model's oldest byte, pop it
   task automatic pop_check(input string nm);
      logic [8:0] e;
      poll_head(nm);
      if (mq.size() == 0) begin
         fail_now({nm, "_model_empty"});
         return;
      end
      e = mq[0];
      rd_chk(4'h0, {24'd0, e[8:1]}, {nm, "_out"});
      rd_chk(4'h8, {31'd0, e[0]}, {nm, "_tlast"});
      wr_next(32'd1);
      void'(mq.pop_front());
   endtask

   // Offer one beat; returns at #1 after the accepting edge
   task automatic push_beat(input logic [7:0] d, input logic l);
      logic acc;
      acc        = 1'b0;
      bus.tdata  = d;
      bus.tlast  = l;
      bus.tvalid = 1'b1;
      for (int i = 0; i < 200 && !acc; i++) begin
         @(negedge clk); acc = bus.tready;
         @(posedge clk); #1;
      end
      bus.tvalid = 1'b0;
      if (acc) mq.push_back({d, l});
      else fail_now("push_timeout");
   endtask

   task automatic stream_prod();
      int   i, guard;
      logic acc;
      i = 0;
      guard = 0;
      bus.tvalid = 1'b1;
      while (i < 64 && guard < 5000) begin
         bus.tdata = 8'(i * 7 + 3);
         bus.tlast = (i % 8 == 7);
         @(negedge clk); acc = bus.tready;
         @(posedge clk); #1;
         guard++;
         if (acc) begin
            mq.push_back({bus.tdata, bus.tlast});
            i++;
         end
      end
      bus.tvalid = 1'b0;
      if (i < 64) fail_now("stream_prod");
   endtask

   task automatic stream_cons();
      for (int k = 0; k < 64; k++) pop_check("stream");
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.valid = 1'b0; bus.address = '0; bus.wdata = '0; bus.wstrb = '0;
      bus.tdata = '0;   bus.tvalid = 1'b0; bus.tlast = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_rdata", bus.rdata, 32'd0);
      check("reset_ready", {31'd0, bus.ready}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle_tready", {31'd0, bus.tready}, 32'd1);
      rd_chk(4'h4, 32'd1, "idle_empty");
      rd_chk(4'h0, 32'd0, "idle_out");
      rd_chk(4'h8, 32'd0, "idle_tlast");

      // First beat latency: hidden at N+1, visible at N+3
      push_beat(8'hA5, 1'b0);
      rd_chk(4'h4, 32'd1, "lat_n1_empty");
      rd_chk(4'h4, 32'd0, "lat_n3_empty");
      push_beat(8'h3C, 1'b1);
      rd_chk(4'h0, 32'h0000_00A5, "a5_out");
      rd_chk(4'h8, 32'd0, "a5_tlast");
      wr_next(32'd1);
      void'(mq.pop_front());
      poll_head("b3c");
      rd_chk(4'h0, 32'h0000_003C, "3c_out");
      rd_chk(4'h8, 32'd1, "3c_tlast");
      wr_next(32'd1);
      void'(mq.pop_front());
      rd_chk(4'h4, 32'd1, "drained_empty");

      // NEXT ignored with wdata[0]=0 or with no head
      wr_next(32'd0);
      wr_next(32'd1);
      rd_chk(4'h4, 32'd1, "noop_empty");
      push_beat(8'h77, 1'b0);
      poll_head("b77");
      wr_next(32'hFFFF_FFFE);
      rd_chk(4'h0, 32'h0000_0077, "next0_keeps_head");
      rd_chk(4'hC, 32'd0, "next_read_zero");
      pop_check("b77");
      rd_chk(4'h4, 32'd1, "b77_empty");

      // Fill FIFO plus head, then a held beat waits for one pop
      for (int i = 0; i < 17; i++) push_beat(8'(8'h20 + i), i == 16);
      repeat (3) @(posedge clk);
      #1;
      bus.tdata = 8'h11; bus.tlast = 1'b0; bus.tvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("full_tready", {31'd0, bus.tready}, 32'd0);
      end
      @(posedge clk); #1;
      fork
         push_beat(8'h11, 1'b0);
         begin
            poll_head("fill");
            rd_chk(4'h0, 32'h0000_0020, "fill_head");
            pop_check("fill_pop");
         end
      join
      for (int i = 0; i < 16; i++) pop_check("fill_drain");
      poll_head("held");
      rd_chk(4'h0, 32'h0000_0011, "held_beat");
      pop_check("held_pop");
      rd_chk(4'h4, 32'd1, "fill_empty");

      // Mid-frame reset drops everything
      for (int i = 0; i < 5; i++) push_beat(8'(8'h50 + i), 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_tready", {31'd0, bus.tready}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      mq.delete();
      rd_chk(4'h4, 32'd1, "rst_empty");
      repeat (4) @(posedge clk);
      #1;
      rd_chk(4'h4, 32'd1, "rst_empty_late");
      rd_chk(4'h0, 32'd0, "rst_out");
      push_beat(8'h01, 1'b0);
      push_beat(8'h02, 1'b0);
      push_beat(8'h03, 1'b1);
      poll_head("f2");
      rd_chk(4'h0, 32'h0000_0001, "f2_first");
      for (int i = 0; i < 3; i++) pop_check("f2");
      rd_chk(4'h4, 32'd1, "f2_empty");

      // Continuous stream against fastest CPU consumer
      fork
         stream_prod();
         stream_cons();
      join
      check("stream_model_drained", mq.size(), 32'd0);
      rd_chk(4'h4, 32'd1, "stream_empty");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/iob_axistream_in.md
Name: iob_axistream_in

Overview:
- AXI4-Stream byte receiver with a CPU-side register interface.
- Accepts 8-bit tdata/tlast beats from an external streaming source and buffers them in a synchronous FIFO.
- Presents the head byte plus its tlast flag to software through memory-mapped registers; software consumes bytes one at a time.
- Sits on the peripheral bus next to the stream transmitter and forms its receive counterpart.

Parameters:
- DATA_W, 32, CPU data width.
- ADDR_W, 4, CPU byte-address width; register select uses address[3:2].
- FIFO_DEPTH_LOG2, 4, log2 of FIFO depth in 9-bit entries (default 16 entries).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- valid  in  1  CPU request strobe.
- address  in  ADDR_W  CPU byte address.
- wdata  in  DATA_W  CPU write data.
- wstrb  in  DATA_W/8  write strobes; nonzero = write, zero = read.
- rdata  out  DATA_W  CPU read data; valid while ready=1.
- ready  out  1  CPU acknowledge.
- tdata  in  8  stream data.
- tvalid  in  1  stream beat valid.
- tready  out  1  receiver can accept a beat.
- tlast  in  1  last beat of frame.

Behaviour:
- Reset (async): ready=0, rdata=0, tready=0; FIFO empty; head_valid=0; frame counter=0.
- Stream side:
  - tready = ~fifo_full, registered-free combinational from FIFO status; forced 0 while rst is high.
  - A beat is accepted when tvalid & tready; {tdata,tlast} is written as one 9-bit entry, tlast in the LSB.
  - tdata/tlast are ignored when tvalid=0.
  - Full FIFO: tready=0 and nothing is written.
- Head register (prefetch FSM, states IDLE / FETCH / HOLD):
  - IDLE: when ~fifo_empty & ~head_valid, assert r_en for one cycle, go to FETCH.
  - FETCH: the FIFO's registered r_data is valid; load head_data/head_last, set head_valid=1, go to HOLD.
  - HOLD: wait for a CPU pop. On pop, clear head_valid and return to IDLE.
  - Latency: a beat accepted at cycle N into an empty block is visible (EMPTY reads 0) at cycle N+3.
  - A pop in HOLD while the FIFO is non-empty reaches HOLD again after 2 cycles. Back-to-back CPU reads of EMPTY must therefore poll.
- Simultaneous events:
  - Stream write and prefetch read in the same cycle are both honoured; FIFO level is unchanged.
  - Stream write into a full FIFO while a prefetch r_en occurs is blocked for that cycle, since tready is computed from pre-read status.
- CPU interface:
  - ready pulses 1 cycle after valid, for exactly one cycle per request.
  - rdata is registered and captured on the request cycle.
  - Unmapped read addresses return 0; unmapped write addresses have no effect.
- Register map (word offsets):
  - 0x0 OUT (R): [7:0] = head_data, upper bits 0. Returns 0 if head_valid=0.
  - 0x4 EMPTY (R): [0] = ~head_valid.
  - 0x8 TLAST (R): [0] = head_last & head_valid.
  - 0xC NEXT (W): wdata[0]=1 pops the head. Ignored when head_valid=0 or wdata[0]=0.
  - 0x10 is not decoded with default ADDR_W.
- Frame counter:
  - 16-bit count of bytes popped since the last popped tlast byte; saturates at 0xFFFF.
  - Resets to 0 on the pop of a byte with head_last=1.
  - Readable at OUT[23:8] only when ADDR_W>4; otherwise internal, for debug.
- Mid-operation reset clears all state immediately; any partially read frame is lost.

Decomposition:
- Shared package/header holds:
  - register offsets: OUT=0, EMPTY=1, TLAST=2, NEXT=3 (word index);
  - entry width constant ENTRY_W=9;
  - FSM state encodings: IDLE=2'd0, FETCH=2'd1, HOLD=2'd2.
- One sub-module: the codebase's iob_fifo_sync (W_DATA_W=R_DATA_W=9, ADDR_W=FIFO_DEPTH_LOG2), instantiated unchanged.

Test Plan:
- Reset then idle: tready=1 one cycle after rst deasserts; EMPTY reads 1; OUT reads 0.
- Push bytes 0xA5, 0x3C (tlast on 0x3C) via tvalid/tready:
  - read OUT=0xA5, TLAST=0;
  - write NEXT=1, poll, then read OUT=0x3C, TLAST=1;
  - write NEXT, then EMPTY=1.
- Fill 16 entries plus 1 head with no CPU pops: tready drops to 0 after the 17th accepted beat. A held 18th beat (0x11) is accepted only after one NEXT pop.
- Write NEXT with wdata=0 and with the block empty: no state change; next accepted byte 0x77 is read back intact.
- Assert rst for 1 cycle mid-frame after 5 beats: EMPTY=1, tready low during reset. Next frame bytes 0x01..0x03 are read back in order.
- Continuous streaming of 64 bytes (tvalid held high) with the CPU popping as fast as allowed: every byte is read back in order, with no duplicates and no drops.
